seq_trigger_monitor: RTL and testbench

- Parametrised, multi-channel successor to the single-channel registered NAND/NOR subcircuit cell.
- NCH identical two-stage registered logic cones; each produces a base output.
- A shared rare-event detector counts cycles on which all channels hit the rare condition, arms after THRESH hits, then drives a payload that inverts the base outputs for HOLD cycles.
- Used as a parametrised trigger/payload node in the trojan-detection benchmark subcircuits.

---
 rtl/seq_trigger_pkg.sv | 14 +
 rtl/trig_cone_ch.sv | 35 +++
 rtl/seq_trigger_monitor.sv | 112 +++++++++++
 tb/tb_seq_trigger_monitor.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_trigger_pkg.sv
// Shared types for the sequential trigger monitor.
// Holds the controller state encoding used by the top and its bench.
package seq_trigger_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_ARMED = 2'd2,
        ST_FIRE  = 2'd3
    } state_t;

endpackage

// File: rtl/trig_cone_ch.sv
// One channel of the two-stage registered NAND/NOR cone.
// o_s2 is the stage-2 register; the channel base output is its inverse.
module trig_cone_ch (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    input  logic i_d,
    output logic o_s2
);

    logic r_dq;
    logic r_s2;
    logic w_n1;
    logic w_n2;
    logic w_n3;

    assign w_n1 = ~(i_a & i_b);
    assign w_n2 = ~(r_dq | i_c);
    assign w_n3 = ~(w_n1 & w_n2);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dq <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_dq <= i_d;
            r_s2 <= w_n3;
        end
    end

    assign o_s2 = r_s2;

endmodule

// File: rtl/seq_trigger_monitor.sv
// Multi-channel registered logic cones with a shared rare-event
// counter that arms and then inverts the base outputs for a while.
module seq_trigger_monitor
    import seq_trigger_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int CNT_W  = 8,
    parameter int THRESH = 16,
    parameter int HOLD   = 4,
    parameter int STICKY = 0
) (
    input  logic             I1470_clk,
    input  logic             I1477_rst,
    input  logic [NCH-1:0]   i_a,
    input  logic [NCH-1:0]   i_b,
    input  logic [NCH-1:0]   i_c,
    input  logic [NCH-1:0]   i_d,
    input  logic             i_en,
    input  logic             i_clr,
    output logic [NCH-1:0]   o_base,
    output logic [NCH-1:0]   o_payload,
    output logic             o_trig,
    output logic [CNT_W-1:0] o_count,
    output logic [1:0]       o_state
);

    localparam int HW = $clog2(HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);
    localparam logic [HW-1:0]    HOLD_LD = HW'(HOLD - 1);

    logic [NCH-1:0]   w_s2;
    logic             w_ev;
    logic [CNT_W-1:0] w_cnt_inc;

    logic [1:0]       r_vld;
    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [HW-1:0]    r_hold;
    logic             r_trig;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        trig_cone_ch u_ch (
            .i_clk (I1470_clk),
            .i_rst (I1477_rst),
            .i_a   (i_a[k]),
            .i_b   (i_b[k]),
            .i_c   (i_c[k]),
            .i_d   (i_d[k]),
            .o_s2  (w_s2[k])
        );
    end

    // Rare condition: every channel's base output high on a valid cycle.
    assign w_ev      = i_en & r_vld[1] & ~|w_s2;
    assign w_cnt_inc = (r_count == CNT_MAX) ? r_count : r_count + CNT_W'(1);

    always_ff @(posedge I1470_clk or posedge I1477_rst) begin
        if (I1477_rst) begin
            r_vld   <= 2'b00;
            r_state <= ST_IDLE;
            r_count <= '0;
            r_hold  <= '0;
            r_trig  <= 1'b0;
        end else begin
            r_vld <= {r_vld[0], 1'b1};
            if (i_clr) begin
                r_state <= ST_IDLE;
                r_count <= '0;
                r_hold  <= '0;
                r_trig  <= 1'b0;
            end else begin
                unique case (r_state)
                    ST_IDLE, ST_COUNT: begin
                        if (w_ev) begin
                            r_count <= w_cnt_inc;
                            r_state <= (w_cnt_inc >= THR) ? ST_ARMED : ST_COUNT;
                        end
                    end
                    ST_ARMED: begin
                        if (w_ev) begin
                            r_count <= w_cnt_inc;
                            r_state <= ST_FIRE;
                            r_hold  <= HOLD_LD;
                            r_trig  <= 1'b1;
                        end
                    end
                    ST_FIRE: begin
                        if (r_hold != '0) begin
                            r_hold <= r_hold - HW'(1);
                        end else if (STICKY == 0) begin
                            r_state <= ST_IDLE;
                            r_count <= '0;
                            r_trig  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_trig  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_base    = ~w_s2;
    assign o_payload = o_base ^ {NCH{r_trig}};
    assign o_trig    = r_trig;
    assign o_count   = r_count;
    assign o_state   = r_state;

endmodule

// File: tb/tb_seq_trigger_monitor.sv
// Randomised bench for seq_trigger_monitor: a default instance and a
// saturating sticky instance share stimulus and are checked against a model.
module tb_seq_trigger_monitor;

    logic       clk;
    logic       rst;
    logic [3:0] a, b, c, d;
    logic       en, clr;

    logic [3:0] base0, pay0, base1, pay1;
    logic       trig0, trig1;
    logic [7:0] cnt0;
    logic [3:0] cnt1;
    logic [1:0] st0, st1;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        int cnt;
        int ph;
        int left;
    } ctl_t;

    ctl_t     m0, m1;
    bit [3:0] base_m, dq_m;
    int       vld_m;

    seq_trigger_monitor u_dflt (
        .I1470_clk (clk),
        .I1477_rst (rst),
        .i_a       (a),
        .i_b       (b),
        .i_c       (c),
        .i_d       (d),
        .i_en      (en),
        .i_clr     (clr),
        .o_base    (base0),
        .o_payload (pay0),
        .o_trig    (trig0),
        .o_count   (cnt0),
        .o_state   (st0)
    );

    seq_trigger_monitor #(
        .NCH(4), .CNT_W(4), .THRESH(15), .HOLD(4), .STICKY(1)
    ) u_stky (
        .I1470_clk (clk),
        .I1477_rst (rst),
        .i_a       (a),
        .i_b       (b),
        .i_c       (c),
        .i_d       (d),
        .i_en      (en),
        .i_clr     (clr),
        .o_base    (base1),
        .o_payload (pay1),
        .o_trig    (trig1),
        .o_count   (cnt1),
        .o_state   (st1)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Phases: 0 idle, 1 counting, 2 armed, 3 firing; left = fire cycles remaining.
    function automatic ctl_t ctl_step(ctl_t m, bit ev, bit cl,
                                      int thr, int hold, bit sticky, int maxc);
        ctl_t r = m;
        if (cl) begin
            r.ph = 0; r.cnt = 0; r.left = 0;
        end else if (m.ph == 3) begin
            if (m.left > 1) r.left = m.left - 1;
            else if (!sticky) begin r.ph = 0; r.cnt = 0; end
        end else if (ev) begin
            r.cnt = (m.cnt < maxc) ? m.cnt + 1 : maxc;
            if (m.ph == 2) begin r.ph = 3; r.left = hold; end
            else r.ph = (r.cnt >= thr) ? 2 : 1;
        end
        return r;
    endfunction

    task automatic model_reset();
        m0 = '{0, 0, 0};
        m1 = '{0, 0, 0};
        base_m = 4'hF;
        dq_m = 4'h0;
        vld_m = 0;
    endtask

    task automatic compare_all();
        check("base0", 32'(base0), 32'(base_m));
        check("pay0", 32'(pay0), 32'(base_m ^ {4{m0.ph == 3}}));
        check("trig0", 32'(trig0), 32'(m0.ph == 3));
        check("count0", 32'(cnt0), 32'(m0.cnt));
        check("state0", 32'(st0), 32'(m0.ph));
        check("base1", 32'(base1), 32'(base_m));
        check("pay1", 32'(pay1), 32'(base_m ^ {4{m1.ph == 3}}));
        check("trig1", 32'(trig1), 32'(m1.ph == 3));
        check("count1", 32'(cnt1), 32'(m1.cnt));
        check("state1", 32'(st1), 32'(m1.ph));
    endtask

    task automatic cyc();
        bit ev;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            ev = en && (vld_m >= 2) && (base_m == 4'hF);
            m0 = ctl_step(m0, ev, clr, 16, 4, 1'b0, 255);
            m1 = ctl_step(m1, ev, clr, 15, 4, 1'b1, 15);
            base_m = ~((a & b) | c | dq_m);
            dq_m = d;
            if (vld_m < 2) vld_m++;
        end
        #1 compare_all();
    endtask

    // quiet = every channel meets the rare condition next cycle
    task automatic drive(bit quiet, bit e, bit cl);
        if (quiet) begin
            a = 4'($urandom);
            b = 4'($urandom) & ~a;
            c = 4'h0;
            d = 4'h0;
        end else begin
            {a, b, c, d} = 16'($urandom);
        end
        en = e;
        clr = cl;
    endtask

    initial begin
        bit armed;
        clk = 1'b0;
        rst = 1'b1;
        {a, b, c, d} = '0;
        en = 1'b0;
        clr = 1'b0;
        model_reset();
        #12;
        compare_all();
        cyc();
        @(negedge clk);
        rst = 1'b0;

        repeat (2) begin drive(1, 1, 0); cyc(); end
        check("no_count_early", 32'(cnt0), 32'd0);

        repeat (40) begin drive(1, 1, 0); cyc(); end
        repeat (110) begin drive(1, 1, 0); cyc(); end
        check("sticky_held", 32'(trig1), 32'd1);
        check("sat_count", 32'(cnt1), 32'd15);
        drive(1, 1, 1); cyc();

        for (int i = 0; i < 24; i++) begin drive(1, i[0], 0); cyc(); end
        drive(1, 0, 0);
        repeat (5) cyc();

        drive(1, 1, 1); cyc();
        armed = 0;
        for (int i = 0; i < 40 && !armed; i++) begin
            drive(1, 1, 0); cyc();
            armed = (m0.ph == 2);
        end
        check("arm_reached", 32'(armed), 32'd1);
        drive(1, 1, 1); cyc();
        check("clr_beats_ev", 32'(st0), 32'd0);
        drive(1, 1, 0); cyc();
        check("no_fire_after_clr", 32'(trig0), 32'd0);

        a = 4'h0; b = 4'h0; c = 4'h0; d = 4'h1; en = 1'b0; clr = 1'b0;
        cyc();
        d = 4'h0;
        repeat (3) cyc();
        a = 4'h2; b = 4'h2;
        repeat (2) cyc();

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 99) < 85, $urandom_range(0, 9) < 8,
                  $urandom_range(0, 99) < 2);
            cyc();
        end

        repeat (20) begin drive(1, 1, 0); cyc(); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_base", 32'(base0), 32'hF);
        check("rst_pay", 32'(pay0), 32'hF);
        check("rst_state", 32'(st0), 32'd0);
        check("rst_count", 32'(cnt0), 32'd0);
        check("rst_pay1", 32'(pay1), 32'hF);
        check("rst_trig1", 32'(trig1), 32'd0);
        model_reset();
        repeat (2) cyc();
        @(negedge clk);
        rst = 1'b0;
        repeat (30) begin drive(1, 1, 0); cyc(); end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
